dcache_tag_arbiter: RTL and testbench
=====================================

Name: dcache_tag_arbiter

Overview:
- Parametrised successor to the fixed 4-port tag compare and arbitration stage of the non-blocking L1 dcache.
- Arbitrates NR_PORTS masters onto the shared per-way tag, data and valid/dirty SRAM bank, returns read data one cycle after grant, and computes the per-way hit vector against the late-arriving tag.
- Adds a round-robin arbitration mode, per-port read-valid strobes, a multi-hit error flag and a synchronous clear.
- Sits between the cache controllers/miss handler and the SRAM arrays. Port 0 is always the miss handler.

Parameters:
- NR_PORTS, 4, number of masters (>=2); port 0 is the miss handler.
- SET_ASSOC, 8, number of ways.
- INDEX_WIDTH, 12, byte-index address width.
- BYTE_OFFSET, 4, low address bits dropped for the SRAM word address.
- TAG_WIDTH, 44, tag width.
- LINE_WIDTH, 128, data line width in bits.
- ARB_MODE, ARB_FIXED, ARB_FIXED or ARB_RR; applies to ports 1..NR_PORTS-1.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- clr_i  in  1  synchronous clear, active high
- req_i  in  NR_PORTS x SET_ASSOC  per-port way-select request; a port requests when any bit is set
- addr_i  in  NR_PORTS x INDEX_WIDTH  index address
- wdata_i  in  NR_PORTS x line_t  tag, data, valid, dirty
- we_i  in  NR_PORTS  write enable
- be_i  in  NR_PORTS x line_be_t  byte enables
- tag_i  in  NR_PORTS x TAG_WIDTH  compare tag, sampled the cycle after grant
- gnt_o  out  NR_PORTS  one-hot grant
- rvalid_o  out  NR_PORTS  read data valid, one cycle after a granted read
- rdata_o  out  SET_ASSOC x line_t  read line per way, broadcast to all ports
- hit_way_o  out  SET_ASSOC  per-way hit vector
- multi_hit_o  out  1  more than one way hit
- req_o  out  SET_ASSOC  SRAM way requests
- addr_o  out  INDEX_WIDTH  SRAM address
- we_o  out  1  SRAM write enable
- wdata_o  out  line_t  SRAM write data
- be_o  out  line_be_t  SRAM byte enables
- rdata_i  in  SET_ASSOC x line_t  SRAM read data, one-cycle latency

Behaviour:
- Reset and clear state: rr_q=1, id_q=0, rd_pend_q=0. After reset, all outputs are 0 until a request arrives.
- Arbitration is combinational and grants at most one port per cycle.
  - Port 0 wins whenever it requests.
  - Otherwise ARB_FIXED: lowest-indexed requesting port wins.
  - Otherwise ARB_RR: first requesting port at or after rr_q, wrapping from NR_PORTS-1 back to 1 (never to 0).
  - rr_q <= winner+1, wrapping to 1, only when the winner is >=1. A port-0 grant leaves rr_q unchanged.
- Forwarding: in the grant cycle, req_o/addr_o/we_o/wdata_o/be_o carry the winning port's values combinationally. With no grant, req_o=0, we_o=0 and the rest are don't-care (driven 0).
- clr_i=1: no grant in that cycle. Next cycle rr_q=1, rd_pend_q=0, and rvalid_o is suppressed even if a read was granted the cycle before.
- Read pipeline: a granted read (we_i=0) in cycle t sets rd_pend_q=1 and id_q=winner. In t+1:
  - rvalid_o[id_q]=1.
  - rdata_o = rdata_i.
  - hit_way_o[w] = rdata_i[w].valid && rdata_i[w].tag == tag_i[id_q].
  - multi_hit_o = popcount(hit_way_o) > 1.
- Outside an rvalid cycle, rdata_o is undefined, hit_way_o=0 and multi_hit_o=0.
- Writes produce no rvalid_o.
- Back-to-back: a new grant in t+1 is legal while the t read is being returned. Throughput is one access per cycle.
- Holding req_i without a grant is allowed. Masters must keep addr/wdata stable until granted.
- Reset mid-read: the pending rvalid is dropped.

Decomposition:
- Package dcache_arb_pkg holds:
  - the arb_mode_e enum {ARB_FIXED, ARB_RR};
  - parametrised line_t and line_be_t, built via a type-parameter pattern (tag, data, valid, dirty fields), with the matching struct in std_cache_pkg reused at default sizes.
- One sub-module: dcache_rr_arb. It takes an N-1 request vector and returns a one-hot grant with its pointer register. It is instantiated only when ARB_MODE==ARB_RR; otherwise a priority encoder is used.

Test Plan:
- Reset, then port 2 issues a read at addr 0x040 with tag_i[2]=0x1234 the next cycle, and way 3 holds valid tag 0x1234 → gnt_o=0b0100; next cycle rvalid_o=0b0100, hit_way_o=0x08, multi_hit_o=0.
- Ports 0, 1 and 3 request simultaneously for 3 cycles, ARB_MODE=ARB_RR → grants are 0, 0, 0 while port 0 holds. Drop port 0 → grants 1, 3, 1, 3.
- ARB_RR, ports 1, 2 and 3 request continuously for 6 cycles → grant sequence 1, 2, 3, 1, 2, 3, with rr_q wrapping from 3 back to 1.
- Port 1 writes (we=1, be all-ones) → gnt_o=0b0010, we_o=1, wdata_o equals wdata_i[1]; rvalid_o stays 0 the next cycle.
- Ways 2 and 5 both valid with tag 0xABC, read with tag 0xABC → hit_way_o=0x24, multi_hit_o=1.
- Read granted in cycle t and clr_i asserted in t → no grant in t, rvalid_o=0 in t+1, rr_q=1.

Source files
------------

// File: rtl/dcache_arb_pkg.sv
// Shared types for the dcache tag/arbitration stage: arbitration mode and the
// default-sized cache line / byte-enable structs used as type-parameter defaults.
package dcache_arb_pkg;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_e;

    localparam int unsigned DFLT_TAG_WIDTH  = 44;
    localparam int unsigned DFLT_LINE_WIDTH = 128;
    localparam int unsigned DFLT_SET_ASSOC  = 8;

    typedef struct packed {
        logic [DFLT_TAG_WIDTH-1:0]  tag;
        logic [DFLT_LINE_WIDTH-1:0] data;
        logic                       valid;
        logic                       dirty;
    } cache_line_t;

    typedef struct packed {
        logic [(DFLT_TAG_WIDTH+7)/8-1:0] tag;
        logic [DFLT_LINE_WIDTH/8-1:0]    data;
        logic [DFLT_SET_ASSOC-1:0]       vldrty;
    } cache_line_be_t;

endpackage

// File: rtl/dcache_rr_arb.sv
// Round-robin arbiter over N requesters; the pointer names the first requester
// considered next cycle and moves past the winner only when en_i is set.
module dcache_rr_arb #(
    parameter int N = 3
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [N-1:0] req_i,
    output logic [N-1:0] gnt_o
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q, ptr_d;
    logic [N-1:0]  req_hi;

    // Requests at or above the pointer win first; otherwise wrap to the lowest.
    assign req_hi = req_i & ({N{1'b1}} << ptr_q);
    assign gnt_o  = (|req_hi) ? (req_hi & (~req_hi + N'(1)))
                              : (req_i & (~req_i + N'(1)));

    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (en_i) begin
            for (int i = 0; i < N; i++) begin
                if (gnt_o[i]) ptr_d = (i == N-1) ? '0 : PW'(i + 1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) ptr_q <= '0;
        else         ptr_q <= ptr_d;
    end

endmodule

// File: rtl/dcache_tag_arbiter.sv
// Arbitrates NR_PORTS masters onto the shared tag/data SRAM bank, returns the
// read line one cycle after grant and computes the per-way hit vector.
module dcache_tag_arbiter
    import dcache_arb_pkg::*;
#(
    parameter int        NR_PORTS    = 4,
    parameter int        SET_ASSOC   = 8,
    parameter int        INDEX_WIDTH = 12,
    parameter int        BYTE_OFFSET = 4,
    parameter int        TAG_WIDTH   = 44,
    parameter int        LINE_WIDTH  = 128,
    parameter arb_mode_e ARB_MODE    = ARB_FIXED,
    parameter type       line_t      = cache_line_t,
    parameter type       line_be_t   = cache_line_be_t
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  clr_i,
    input  logic [NR_PORTS-1:0][SET_ASSOC-1:0]    req_i,
    input  logic [NR_PORTS-1:0][INDEX_WIDTH-1:0]  addr_i,
    input  line_t [NR_PORTS-1:0]                  wdata_i,
    input  logic [NR_PORTS-1:0]                   we_i,
    input  line_be_t [NR_PORTS-1:0]               be_i,
    input  logic [NR_PORTS-1:0][TAG_WIDTH-1:0]    tag_i,
    output logic [NR_PORTS-1:0]                   gnt_o,
    output logic [NR_PORTS-1:0]                   rvalid_o,
    output line_t [SET_ASSOC-1:0]                 rdata_o,
    output logic [SET_ASSOC-1:0]                  hit_way_o,
    output logic                                  multi_hit_o,
    output logic [SET_ASSOC-1:0]                  req_o,
    output logic [INDEX_WIDTH-1:0]                addr_o,
    output logic                                  we_o,
    output line_t                                 wdata_o,
    output line_be_t                              be_o,
    input  line_t [SET_ASSOC-1:0]                 rdata_i
);

    localparam int M   = NR_PORTS - 1;
    localparam int IDW = $clog2(NR_PORTS);

    // The SRAM drops the low BYTE_OFFSET bits itself; the full index is forwarded.
    if (NR_PORTS < 2 || BYTE_OFFSET >= INDEX_WIDTH ||
        $bits(line_t) != TAG_WIDTH + LINE_WIDTH + 2) begin : g_bad_cfg
        $error("dcache_tag_arbiter: unsupported parameterisation");
    end

    logic [NR_PORTS-1:0] req_v;
    logic [M-1:0]        sub_req, sub_gnt;
    logic [IDW-1:0]      win, id_q, id_d;
    logic                rd_pend_q, rd_pend_d;

    for (genvar p = 0; p < NR_PORTS; p++) begin : g_reqv
        assign req_v[p] = |req_i[p];
    end

    assign sub_req = req_v[NR_PORTS-1:1];

    if (ARB_MODE == ARB_RR) begin : g_rr
        dcache_rr_arb #(.N(M)) u_rr_arb (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .clr_i  (clr_i),
            .en_i   (!clr_i && !req_v[0]),
            .req_i  (sub_req),
            .gnt_o  (sub_gnt)
        );
    end else begin : g_fixed
        assign sub_gnt = sub_req & (~sub_req + M'(1));
    end

    // The miss handler on port 0 always pre-empts the other masters.
    assign gnt_o = clr_i    ? '0 :
                   req_v[0] ? NR_PORTS'(1) : {sub_gnt, 1'b0};

    always_comb begin
        win = '0;
        for (int p = 0; p < NR_PORTS; p++) begin
            if (gnt_o[p]) win = IDW'(p);
        end
    end

    always_comb begin
        req_o   = '0;
        addr_o  = '0;
        we_o    = 1'b0;
        wdata_o = '0;
        be_o    = '0;
        if (|gnt_o) begin
            req_o   = req_i[win];
            addr_o  = addr_i[win];
            we_o    = we_i[win];
            wdata_o = wdata_i[win];
            be_o    = be_i[win];
        end
    end

    assign rd_pend_d = (|gnt_o) && !we_i[win];
    assign id_d      = clr_i ? '0 : (rd_pend_d ? win : id_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_pend_q <= 1'b0;
            id_q      <= '0;
        end else begin
            rd_pend_q <= rd_pend_d;
            id_q      <= id_d;
        end
    end

    // The compare tag arrives late, in the return cycle, from the granted port.
    always_comb begin
        rvalid_o  = '0;
        rdata_o   = '0;
        hit_way_o = '0;
        if (rd_pend_q) begin
            rvalid_o[id_q] = 1'b1;
            rdata_o        = rdata_i;
            for (int w = 0; w < SET_ASSOC; w++) begin
                hit_way_o[w] = rdata_i[w].valid && (rdata_i[w].tag == tag_i[id_q]);
            end
        end
    end

    assign multi_hit_o = |(hit_way_o & (hit_way_o - SET_ASSOC'(1)));

endmodule

// File: tb/tb_dcache_tag_arbiter.sv
// Directed bench: cycle table for arbitration/rvalid plus hand sequences for
// hit compare, multi-hit, write forwarding and reset behaviour.
module tb_dcache_tag_arbiter;
    import dcache_arb_pkg::*;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    clr;
    logic [3:0][7:0]         req;
    logic [3:0][11:0]        addr;
    cache_line_t [3:0]       wdata;
    logic [3:0]              we;
    cache_line_be_t [3:0]    be;
    logic [3:0][43:0]        tag;
    cache_line_t [7:0]       rdata_in;

    logic [3:0]              gnt, rvalid, gnt_f, rvalid_f;
    cache_line_t [7:0]       rdata_out, rdata_out_f;
    logic [7:0]              hit, hit_f, req_out, req_out_f;
    logic                    multi, multi_f, we_out, we_out_f;
    logic [11:0]             addr_out, addr_out_f;
    cache_line_t             wdata_out, wdata_out_f;
    cache_line_be_t          be_out, be_out_f;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dcache_tag_arbiter #(.ARB_MODE(ARB_RR)) dut (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .req_i(req), .addr_i(addr),
        .wdata_i(wdata), .we_i(we), .be_i(be), .tag_i(tag), .gnt_o(gnt),
        .rvalid_o(rvalid), .rdata_o(rdata_out), .hit_way_o(hit), .multi_hit_o(multi),
        .req_o(req_out), .addr_o(addr_out), .we_o(we_out), .wdata_o(wdata_out),
        .be_o(be_out), .rdata_i(rdata_in)
    );

    dcache_tag_arbiter #(.ARB_MODE(ARB_FIXED)) dut_fx (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .req_i(req), .addr_i(addr),
        .wdata_i(wdata), .we_i(we), .be_i(be), .tag_i(tag), .gnt_o(gnt_f),
        .rvalid_o(rvalid_f), .rdata_o(rdata_out_f), .hit_way_o(hit_f), .multi_hit_o(multi_f),
        .req_o(req_out_f), .addr_o(addr_out_f), .we_o(we_out_f), .wdata_o(wdata_out_f),
        .be_o(be_out_f), .rdata_i(rdata_in)
    );

    typedef struct {
        logic [3:0] rq;
        logic [3:0] wr;
        logic       cl;
        logic [3:0] e_gnt;
        logic [3:0] e_gnt_fx;
        logic [3:0] e_rvalid;
        logic       e_we;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic [3:0] rq, input logic [3:0] wr, input logic cl,
                       input logic [3:0] eg, input logic [3:0] egf,
                       input logic [3:0] erv, input logic ewe);
        vec_t v;
        v.rq = rq; v.wr = wr; v.cl = cl;
        v.e_gnt = eg; v.e_gnt_fx = egf; v.e_rvalid = erv; v.e_we = ewe;
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        clr = 1'b0;
        req = '0;
        we  = '0;
        tag = '0;
        rdata_in = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        for (int p = 0; p < 4; p++) begin
            addr[p]        = 12'(p * 32);
            wdata[p].tag   = 44'(16'hA000 + p);
            wdata[p].data  = {4{32'(32'hC0DE_0000 + p)}};
            wdata[p].valid = 1'b1;
            wdata[p].dirty = p[0];
            be[p]          = '0;
        end
        be[1] = '1;

        // cycle table: req mask, we mask, clr, gnt(rr), gnt(fixed), rvalid(rr), we_o
        add(4'b1011, 4'b0000, 1'b0, 4'b0001, 4'b0001, 4'b0000, 1'b0);
        add(4'b1011, 4'b0000, 1'b0, 4'b0001, 4'b0001, 4'b0001, 1'b0);
        add(4'b1011, 4'b0000, 1'b0, 4'b0001, 4'b0001, 4'b0001, 1'b0);
        add(4'b1010, 4'b0000, 1'b0, 4'b0010, 4'b0010, 4'b0001, 1'b0);
        add(4'b1010, 4'b0000, 1'b0, 4'b1000, 4'b0010, 4'b0010, 1'b0);
        add(4'b1010, 4'b0000, 1'b0, 4'b0010, 4'b0010, 4'b1000, 1'b0);
        add(4'b1010, 4'b0000, 1'b0, 4'b1000, 4'b0010, 4'b0010, 1'b0);
        add(4'b1110, 4'b0000, 1'b0, 4'b0010, 4'b0010, 4'b1000, 1'b0);
        add(4'b1110, 4'b0000, 1'b0, 4'b0100, 4'b0010, 4'b0010, 1'b0);
        add(4'b1110, 4'b0000, 1'b0, 4'b1000, 4'b0010, 4'b0100, 1'b0);
        add(4'b1110, 4'b0000, 1'b0, 4'b0010, 4'b0010, 4'b1000, 1'b0);
        add(4'b1110, 4'b0000, 1'b0, 4'b0100, 4'b0010, 4'b0010, 1'b0);
        add(4'b1110, 4'b0000, 1'b0, 4'b1000, 4'b0010, 4'b0100, 1'b0);
        add(4'b0010, 4'b0010, 1'b0, 4'b0010, 4'b0010, 4'b1000, 1'b1);
        add(4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        add(4'b0100, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        add(4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        add(4'b1110, 4'b0000, 1'b0, 4'b0010, 4'b0010, 4'b0000, 1'b0);
        add(4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0010, 1'b0);
        add(4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0);

        do_reset();
        @(negedge clk);
        chk("reset gnt", gnt, 4'b0);
        chk("reset rvalid", rvalid, 4'b0);
        chk("reset hit", hit, 8'h0);
        chk("reset multi", multi, 1'b0);
        chk("reset req_o", req_out, 8'h0);
        chk("reset we_o", we_out, 1'b0);
        chk("reset addr_o", addr_out, 12'h0);

        foreach (vq[i]) begin
            @(posedge clk); #1;
            clr = vq[i].cl;
            for (int p = 0; p < 4; p++) begin
                req[p] = vq[i].rq[p] ? 8'(8'h01 << p) : 8'h00;
                we[p]  = vq[i].wr[p];
            end
            @(negedge clk);
            chk($sformatf("vec%0d gnt_rr", i), gnt, vq[i].e_gnt);
            chk($sformatf("vec%0d gnt_fixed", i), gnt_f, vq[i].e_gnt_fx);
            chk($sformatf("vec%0d rvalid", i), rvalid, vq[i].e_rvalid);
            chk($sformatf("vec%0d we_o", i), we_out, vq[i].e_we);
        end

        // single hit: port 2 read at 0x040, way 3 valid match, way 1 matching but invalid
        do_reset();
        @(posedge clk); #1;
        req[2] = 8'h08;
        @(negedge clk);
        chk("hit gnt", gnt, 4'b0100);
        chk("hit addr_o", addr_out, 12'h040);
        chk("hit req_o", req_out, 8'h08);
        @(posedge clk); #1;
        req = '0;
        tag[2] = 44'h1234;
        for (int w = 0; w < 8; w++) begin
            rdata_in[w].tag   = 44'(16'h5000 + w);
            rdata_in[w].data  = {4{32'(32'hDA7A_0000 + w)}};
            rdata_in[w].valid = 1'b1;
            rdata_in[w].dirty = 1'b0;
        end
        rdata_in[3].tag   = 44'h1234;
        rdata_in[1].tag   = 44'h1234;
        rdata_in[1].valid = 1'b0;
        @(negedge clk);
        chk("hit rvalid", rvalid, 4'b0100);
        chk("hit way", hit, 8'h08);
        chk("hit multi", multi, 1'b0);
        chk("hit rdata3", rdata_out[3], rdata_in[3]);

        // multi hit: ways 2 and 5 match, way 0 matching but invalid
        @(posedge clk); #1;
        req[1] = 8'hFF;
        @(negedge clk);
        chk("multi gnt", gnt, 4'b0010);
        @(posedge clk); #1;
        req = '0;
        tag[1] = 44'hABC;
        rdata_in[2].tag = 44'hABC;
        rdata_in[5].tag = 44'hABC;
        rdata_in[0].tag = 44'hABC;
        rdata_in[0].valid = 1'b0;
        @(negedge clk);
        chk("multi rvalid", rvalid, 4'b0010);
        chk("multi way", hit, 8'h24);
        chk("multi flag", multi, 1'b1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("idle hit", hit, 8'h00);
        chk("idle multi", multi, 1'b0);

        // write forwarding from port 1
        idle_inputs();
        @(posedge clk); #1;
        req[1] = 8'h02;
        we[1]  = 1'b1;
        @(negedge clk);
        chk("wr gnt", gnt, 4'b0010);
        chk("wr we_o", we_out, 1'b1);
        chk("wr wdata_o", wdata_out, wdata[1]);
        chk("wr be_o", be_out, be[1]);
        chk("wr addr_o", addr_out, 12'h020);
        @(posedge clk); #1;
        req = '0;
        we  = '0;
        @(negedge clk);
        chk("wr rvalid", rvalid, 4'b0000);

        // reset while a read is pending drops the return
        @(posedge clk); #1;
        req[3] = 8'h80;
        @(posedge clk); #1;
        req = '0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst mid-read rvalid", rvalid, 4'b0000);
        #1 rst_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
